// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock FIFO with registered read data, level flags and sticky
// overflow/underflow error flags.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset (highest priority)
//   clr           synchronous flush: empties the FIFO, clears error flags
//   wr_en, din    write request and data
//   rd_en         read request
//   dout          registered read data, holds until the next accepted read
//   dout_valid    one-cycle pulse when dout carries a newly read word
//   full, empty, almost_full, almost_empty
//                 level flags decoded from the registered count
//   count         number of stored words (0..DEPTH)
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was rejected because the FIFO was empty
module sync_fifo_param #(
   parameter int WIDTH    = 9,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   // Acceptance looks only at the registered flags, so a full FIFO cannot
   // take a write even when a read frees a slot in the same cycle, and an
   // empty FIFO never forwards din straight to dout.
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else if (clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
            dout   <= mem[rd_ptr];
         end
         dout_valid <= rd_acc;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   // Storage is deliberately not reset; stale words are unreachable because
   // the read pointer and count are cleared together.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst && !clr) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a default instance (9x8) and a 16x32 instance
// with AF=30/AE=4, both checked every cycle against a queue-based model,
// plus a table of hand-derived expectations for the default instance.
module tb_sync_fifo_param;

   typedef struct {
      bit          wr;
      bit          rd;
      bit          clr;
      bit          rst;
      logic [15:0] din;
   } ctl_t;

   typedef struct packed {
      logic [15:0] dout;
      logic        dv;
      logic [5:0]  count;
      logic        full;
      logic        empty;
      logic        af;
      logic        ae;
      logic        ov;
      logic        un;
   } obs_t;

   typedef struct {
      ctl_t c;
      obs_t e;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance 0: defaults
   logic       r0 = 1'b0, c0 = 1'b0, w0 = 1'b0, rd0 = 1'b0;
   logic [8:0] din0 = '0, dout0;
   logic       dv0, full0, empty0, af0, ae0, ov0, un0;
   logic [3:0] cnt0;

   // instance 1: 16 x 32
   logic        r1 = 1'b0, c1 = 1'b0, w1 = 1'b0, rd1 = 1'b0;
   logic [15:0] din1 = '0, dout1;
   logic        dv1, full1, empty1, af1, ae1, ov1, un1;
   logic [5:0]  cnt1;

   sync_fifo_param u_dut0 (
      .clk(clk), .rst(r0), .clr(c0), .wr_en(w0), .din(din0), .rd_en(rd0),
      .dout(dout0), .dout_valid(dv0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(cnt0),
      .overflow(ov0), .underflow(un0)
   );

   sync_fifo_param #(.WIDTH(16), .DEPTH(32), .AF_LEVEL(30), .AE_LEVEL(4)) u_dut1 (
      .clk(clk), .rst(r1), .clr(c1), .wr_en(w1), .din(din1), .rd_en(rd1),
      .dout(dout1), .dout_valid(dv1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ov1), .underflow(un1)
   );

   int n_vec = 0;
   int n_err = 0;

   int          depth [2] = '{8, 32};
   int          af_l  [2] = '{6, 30};
   int          ae_l  [2] = '{2, 4};
   logic [15:0] dmask [2] = '{16'h01FF, 16'hFFFF};

   // reference model state
   logic [15:0] mq [2][$];
   logic [15:0] m_dout [2];
   logic        m_dv [2];
   logic        m_ov [2];
   logic        m_un [2];

   function automatic ctl_t mk(bit wr, bit rd, bit cl, bit rs, logic [15:0] d);
      ctl_t c;
      c.wr = wr; c.rd = rd; c.clr = cl; c.rst = rs; c.din = d;
      return c;
   endfunction

   function automatic obs_t mkobs(logic [15:0] d, bit dv, int cnt, bit ov, bit un,
                                  int af, int ae, int dep);
      obs_t o;
      o.dout = d; o.dv = dv; o.count = 6'(cnt);
      o.full = (cnt == dep); o.empty = (cnt == 0);
      o.af = (cnt >= af); o.ae = (cnt <= ae);
      o.ov = ov; o.un = un;
      return o;
   endfunction

   function automatic obs_t get_obs(int s);
      obs_t o;
      if (s == 0) begin
         o.dout = {7'b0, dout0}; o.dv = dv0; o.count = {2'b0, cnt0};
         o.full = full0; o.empty = empty0; o.af = af0; o.ae = ae0;
         o.ov = ov0; o.un = un0;
      end else begin
         o.dout = dout1; o.dv = dv1; o.count = cnt1;
         o.full = full1; o.empty = empty1; o.af = af1; o.ae = ae1;
         o.ov = ov1; o.un = un1;
      end
      return o;
   endfunction

   function automatic obs_t model_obs(int s);
      return mkobs(m_dout[s], m_dv[s], mq[s].size(), m_ov[s], m_un[s],
                   af_l[s], ae_l[s], depth[s]);
   endfunction

   task automatic model_upd(int s, ctl_t c);
      int  sz;
      bit  is_full, is_empty;
      sz = mq[s].size();
      is_full  = (sz == depth[s]);
      is_empty = (sz == 0);
      if (c.rst) begin
         mq[s].delete();
         m_dout[s] = '0; m_dv[s] = 1'b0; m_ov[s] = 1'b0; m_un[s] = 1'b0;
      end else if (c.clr) begin
         mq[s].delete();
         m_dv[s] = 1'b0; m_ov[s] = 1'b0; m_un[s] = 1'b0;
      end else begin
         if (c.wr && is_full)  m_ov[s] = 1'b1;
         if (c.rd && is_empty) m_un[s] = 1'b1;
         m_dv[s] = 1'b0;
         if (c.rd && !is_empty) begin
            m_dout[s] = mq[s].pop_front();
            m_dv[s]   = 1'b1;
         end
         if (c.wr && !is_full) mq[s].push_back(c.din & dmask[s]);
      end
   endtask

   task automatic check(int s);
      obs_t act, exp;
      act = get_obs(s);
      exp = model_obs(s);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL model dut%0d t=%0t actual=%h required=%h", s, $time, act, exp);
      end
   endtask

   task automatic step2(ctl_t a, ctl_t b);
      r0 = a.rst; c0 = a.clr; w0 = a.wr; rd0 = a.rd; din0 = a.din[8:0];
      r1 = b.rst; c1 = b.clr; w1 = b.wr; rd1 = b.rd; din1 = b.din;
      @(posedge clk);
      #1;
      model_upd(0, a);
      model_upd(1, b);
      check(0);
      check(1);
   endtask

   task automatic step1(int s, ctl_t c);
      ctl_t idle;
      idle = mk(0, 0, 0, 0, 16'h0);
      if (s == 0) step2(c, idle);
      else        step2(idle, c);
   endtask

   task automatic run_directed(int s);
      int d;
      int n;
      d = depth[s];
      step1(s, mk(0, 0, 0, 1, 0));
      for (int i = 1; i <= d; i++) step1(s, mk(1, 0, 0, 0, 16'(i)));
      step1(s, mk(1, 0, 0, 0, 16'h01FF));
      for (int i = 0; i < d; i++) step1(s, mk(0, 1, 0, 0, 0));
      step1(s, mk(0, 0, 0, 0, 0));
      step1(s, mk(0, 1, 0, 0, 0));
      step1(s, mk(1, 1, 0, 0, 16'h00AA));
      step1(s, mk(0, 1, 0, 0, 0));
      step1(s, mk(0, 0, 0, 0, 0));
      // steady count=4 with simultaneous traffic, long enough to wrap
      step1(s, mk(0, 0, 1, 0, 0));
      for (int i = 0; i < 4; i++) step1(s, mk(1, 0, 0, 0, 16'(16'h0100 + i)));
      n = (d == 8) ? 20 : 40;
      for (int i = 4; i < 4 + n; i++) step1(s, mk(1, 1, 0, 0, 16'(16'h0100 + i)));
      for (int i = 0; i < 5; i++) step1(s, mk(0, 1, 0, 0, 0));
      // full with both requests, then overflow, drain to 5, flush
      for (int i = 0; i < d; i++) step1(s, mk(1, 0, 0, 0, 16'(16'h0030 + i)));
      step1(s, mk(1, 1, 0, 0, 16'h0077));
      step1(s, mk(1, 0, 0, 0, 16'h0078));
      step1(s, mk(1, 0, 0, 0, 16'h0079));
      for (int i = 0; i < d - 5; i++) step1(s, mk(0, 1, 0, 0, 0));
      step1(s, mk(1, 1, 1, 0, 16'h0055));
      step1(s, mk(0, 0, 0, 0, 0));
      // reset mid-burst with every other control active
      for (int i = 0; i < 3; i++) step1(s, mk(1, 0, 0, 0, 16'(16'h0060 + i)));
      step1(s, mk(1, 1, 0, 0, 16'h0063));
      step1(s, mk(1, 1, 1, 1, 16'h0064));
      step1(s, mk(0, 1, 0, 0, 0));
      step1(s, mk(0, 0, 0, 0, 0));
   endtask

   vec_t tbl[$];

   initial begin : main
      vec_t v;
      obs_t act;
      int   c;

      // hand-derived expectations for the default instance
      v.c = mk(0, 0, 0, 1, 0);
      v.e = mkobs(0, 0, 0, 0, 0, 6, 2, 8);
      tbl.push_back(v);
      for (int i = 0; i < 8; i++) begin
         v.c = mk(1, 0, 0, 0, 16'(i + 1));
         v.e = mkobs(0, 0, i + 1, 0, 0, 6, 2, 8);
         tbl.push_back(v);
      end
      v.c = mk(1, 0, 0, 0, 16'h01FF);
      v.e = mkobs(0, 0, 8, 1, 0, 6, 2, 8);
      tbl.push_back(v);
      for (int i = 0; i < 8; i++) begin
         v.c = mk(0, 1, 0, 0, 0);
         v.e = mkobs(16'(i + 1), 1, 7 - i, 1, 0, 6, 2, 8);
         tbl.push_back(v);
      end
      v.c = mk(0, 1, 0, 0, 0);
      v.e = mkobs(16'h0008, 0, 0, 1, 1, 6, 2, 8);
      tbl.push_back(v);
      v.c = mk(1, 1, 0, 0, 16'h00AA);
      v.e = mkobs(16'h0008, 0, 1, 1, 1, 6, 2, 8);
      tbl.push_back(v);
      v.c = mk(0, 1, 0, 0, 0);
      v.e = mkobs(16'h00AA, 1, 0, 1, 1, 6, 2, 8);
      tbl.push_back(v);
      v.c = mk(0, 0, 1, 0, 0);
      v.e = mkobs(16'h00AA, 0, 0, 0, 0, 6, 2, 8);
      tbl.push_back(v);

      step2(mk(0, 0, 0, 1, 0), mk(0, 0, 0, 1, 0));
      step2(mk(0, 0, 0, 1, 0), mk(0, 0, 0, 1, 0));

      foreach (tbl[i]) begin
         step1(0, tbl[i].c);
         act = get_obs(0);
         n_vec++;
         if (act !== tbl[i].e) begin
            n_err++;
            $display("FAIL table[%0d] actual=%h required=%h", i, act, tbl[i].e);
         end
      end

      run_directed(0);
      run_directed(1);

      // random traffic; write-heavy then read-heavy phases reach both ends
      step2(mk(0, 0, 0, 1, 0), mk(0, 0, 0, 1, 0));
      for (int i = 0; i < 1200; i++) begin
         ctl_t a [2];
         for (int s = 0; s < 2; s++) begin
            c = ((i / 150) % 2 == 0) ? 70 : 30;
            a[s] = mk($urandom_range(0, 99) < c, $urandom_range(0, 99) >= c - 10,
                      $urandom_range(0, 79) == 0, $urandom_range(0, 299) == 0,
                      16'($urandom));
         end
         step2(a[0], a[1]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 9, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of storage entries; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost-full threshold; range 1..DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold; range 0..DEPTH-2.
REQ-005 clk  input  1  clock; all state changes on rising edge only.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 clr  input  1  synchronous flush: empties FIFO, clears error flags.
REQ-008 wr_en  input  1  write request.
REQ-009 din  input  WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 dout  output  WIDTH  read data, registered.
REQ-012 dout_valid  output  1  one-cycle pulse: dout holds newly read word.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 almost_full  output  1  count >= AF_LEVEL.
REQ-016 almost_empty  output  1  count <= AE_LEVEL.
REQ-017 count  output  clog2(DEPTH)+1  number of stored words.
REQ-018 overflow  output  1  sticky: write attempted while full and rejected.
REQ-019 underflow  output  1  sticky: read attempted while empty.

Function
REQ-020 Write accepted iff wr_en=1 and full=0 at the edge; din stored at write pointer, write pointer +1 modulo DEPTH.
REQ-021 Read accepted iff rd_en=1 and empty=0; word at read pointer loaded into dout at that edge, read pointer +1 modulo DEPTH, dout_valid=1 the following cycle (latency 1).
REQ-022 No accepted read: dout holds previous value; dout_valid=0.
REQ-023 Pointers are clog2(DEPTH) bits, wrap silently from DEPTH-1 to 0; no storage reordering.
REQ-024 count: +1 on write-only, -1 on read-only, unchanged on both-accepted or neither.
REQ-025 Full with wr_en=1 and rd_en=1: read accepted, write rejected, overflow set; count becomes DEPTH-1.
REQ-026 Empty with wr_en=1 and rd_en=1: write accepted, read rejected, underflow set; count becomes 1; no read-through of din.
REQ-027 Flags full/empty/almost_full/almost_empty are decoded from registered count; update in the same cycle count changes; never both full and empty.
REQ-028 overflow/underflow remain 1 until rst or clr; further rejected attempts have no other effect.
REQ-029 clr=1: pointers and count to 0, overflow/underflow to 0, dout_valid to 0; dout holds value; wr_en/rd_en in the same cycle ignored.
REQ-030 Storage array contents not reset; unread data after clr/rst never visible on dout.

Reset
REQ-031 rst=1 at an edge: pointers=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-032 rst has priority over clr, wr_en, rd_en; reset mid-operation discards all stored words and pending reads.
REQ-033 Outputs are defined (no X, no Z) from the first edge with rst=1 onward.

Verification
REQ-034 Defaults; write 0x001..0x008 on 8 cycles -> full=1, count=8, almost_full=1 from count=6; 9th write 0x1FF -> rejected, overflow=1, count=8.
REQ-035 From full, read 8 cycles -> dout 0x001..0x008 in order, each one cycle after rd_en, dout_valid pulses; then empty=1, almost_empty=1 at count=2.
REQ-036 Empty, rd_en=1 -> underflow=1, dout unchanged, dout_valid=0; same cycle wr_en=1 din=0x0AA -> count=1, next read returns 0x0AA.
REQ-037 count=4, simultaneous wr/rd 20 cycles with incrementing data -> count stays 4, outputs in write order across pointer wrap.
REQ-038 count=5 with overflow=1, assert clr -> count=0, empty=1, overflow=0; assert rst mid-burst -> all REQ-031 values next cycle.
REQ-039 Repeat REQ-034..037 with WIDTH=16, DEPTH=32, AF_LEVEL=30, AE_LEVEL=4; flags at matching thresholds.
